multdiv_ctrl: RTL and testbench

Issue/completion controller sitting directly upstream of the 32-bit Booth multiplier (`mult_32`) and the companion divider. It accepts a multiply or divide request from the execute stage, latches and holds the operands stable for the whole operation, pulses `ctrl_MULT` or `ctrl_DIV`, stalls the pipeline, and waits for the unit's ready flag. It then holds result, exception and destination register for writeback until acknowledged, with a watchdog for units that never report ready.

---
 rtl/multdiv_pkg.sv | 28 ++
 rtl/multdiv_watchdog.sv | 40 ++++
 rtl/multdiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multiply/divide issue controller and its watchdog.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    localparam int DEF_TIMEOUT    = 63;
    localparam int DEF_READY_MASK = 2;
    localparam int CNT_W          = 6;

    // Simultaneous multiply and divide requests resolve to multiply.
    function automatic op_e sel_op(input logic start_mult, input logic start_div);
        if (start_mult || !start_div) begin
            return OP_MULT;
        end
        return OP_DIV;
    endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Wait-cycle counter: reports when the stale-ready mask has elapsed and when the unit has timed out.
module multdiv_watchdog
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int READY_MASK = DEF_READY_MASK
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic mask_done,
    output logic timed_out
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count equals the index of the current WAIT cycle; the last permitted one is TIMEOUT-1.
    assign mask_done = (cnt_q >= CNT_W'(READY_MASK));
    assign timed_out = (cnt_q >= CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !timed_out) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/completion controller for the multiplier and divider: latches operands, pulses start,
// stalls the front end, and holds the result for writeback until acknowledged.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int READY_MASK = DEF_READY_MASK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd,
    output logic [31:0] op_a_q,
    output logic [31:0] op_b_q,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] mult_result,
    input  logic [31:0] div_result,
    input  logic        mult_exception,
    input  logic        div_exception,
    input  logic        mult_ready,
    input  logic        div_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    input  logic        wb_ack
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] op_a_d, op_b_d;
    logic [4:0]  rd_q, rd_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_exc_q, wb_exc_d;

    logic        wd_clr, wd_en;
    logic        mask_done, timed_out;
    logic        req;
    logic        unit_ready, unit_exc;
    logic [31:0] unit_result;

    multdiv_watchdog #(
        .TIMEOUT    (TIMEOUT),
        .READY_MASK (READY_MASK)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clr       (wd_clr),
        .en        (wd_en),
        .mask_done (mask_done),
        .timed_out (timed_out)
    );

    assign req = start_mult | start_div;

    // Only the unit that was started is listened to; the other one's outputs are don't-care.
    assign unit_ready  = (op_q == OP_MULT) ? mult_ready     : div_ready;
    assign unit_result = (op_q == OP_MULT) ? mult_result    : div_result;
    assign unit_exc    = (op_q == OP_MULT) ? mult_exception : div_exception;

    // Stall drops in the acknowledge cycle so the front end resumes without a bubble; reset forces it low.
    assign stall = !reset &&
                   (((state_q != ST_IDLE) && !((state_q == ST_DONE) && wb_ack)) ||
                    ((state_q == ST_IDLE) && req));

    assign ctrl_MULT    = ctrl_mult_q;
    assign ctrl_DIV     = ctrl_div_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rd_d        = rd_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_exc_d    = wb_exc_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d        = sel_op(start_mult, start_div);
                    op_a_d      = operand_a;
                    op_b_d      = operand_b;
                    rd_d        = rd;
                    ctrl_mult_d = (sel_op(start_mult, start_div) == OP_MULT);
                    ctrl_div_d  = (sel_op(start_mult, start_div) == OP_DIV);
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_clr  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // A real ready beats the watchdog when both land in the same cycle.
                if (mask_done && unit_ready) begin
                    wb_data_d  = unit_result;
                    wb_exc_d   = unit_exc;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (timed_out) begin
                    wb_data_d  = '0;
                    wb_exc_d   = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_ack) begin
                    wb_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MULT;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rd_q        <= rd_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a transaction-level timeline model with mocked arithmetic units.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 63;
    localparam int MASK    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd;
    logic [31:0] op_a_q, op_b_q;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] mult_result, div_result;
    logic        mult_exception, div_exception;
    logic        mult_ready, div_ready;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        wb_ack;

    always #5 clk = ~clk;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT), .READY_MASK(MASK)) dut (
        .clk(clk), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .operand_a(operand_a), .operand_b(operand_b), .rd(rd),
        .op_a_q(op_a_q), .op_b_q(op_b_q),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .mult_result(mult_result), .div_result(div_result),
        .mult_exception(mult_exception), .div_exception(div_exception),
        .mult_ready(mult_ready), .div_ready(div_ready),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exception(wb_exception), .wb_ack(wb_ack)
    );

    int n_cmp = 0;
    int n_err = 0;

    bit          chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_cm = 1'b0, exp_cd = 1'b0, exp_valid = 1'b0, exp_exc = 1'b0;
    logic [31:0] exp_data = '0, exp_opa = '0, exp_opb = '0;
    logic [4:0]  exp_rd = '0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic units: {exception, result}.
    function automatic logic [32:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        return {p != longint'($signed(p[31:0])), p[31:0]};
    endfunction

    function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'($urandom_range(0, 20));
            2: return 32'(-int'($urandom_range(1, 20)));
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {32'h0, stall}, {32'h0, exp_stall});
            chk("ctrl_MULT", {32'h0, ctrl_MULT}, {32'h0, exp_cm});
            chk("ctrl_DIV", {32'h0, ctrl_DIV}, {32'h0, exp_cd});
            chk("wb_valid", {32'h0, wb_valid}, {32'h0, exp_valid});
            chk("op_a_q", {1'b0, op_a_q}, {1'b0, exp_opa});
            chk("op_b_q", {1'b0, op_b_q}, {1'b0, exp_opb});
            if (exp_valid) begin
                chk("wb_data", {1'b0, wb_data}, {1'b0, exp_data});
                chk("wb_rd", {28'h0, wb_rd}, {28'h0, exp_rd});
                chk("wb_exception", {32'h0, wb_exception}, {32'h0, exp_exc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, {32'h0, stall}, 33'h0);
        chk({tag, "_ctrl_MULT"}, {32'h0, ctrl_MULT}, 33'h0);
        chk({tag, "_ctrl_DIV"}, {32'h0, ctrl_DIV}, 33'h0);
        chk({tag, "_wb_valid"}, {32'h0, wb_valid}, 33'h0);
        chk({tag, "_wb_exception"}, {32'h0, wb_exception}, 33'h0);
        chk({tag, "_wb_data"}, {1'b0, wb_data}, 33'h0);
        chk({tag, "_wb_rd"}, {28'h0, wb_rd}, 33'h0);
        chk({tag, "_op_a_q"}, {1'b0, op_a_q}, 33'h0);
        chk({tag, "_op_b_q"}, {1'b0, op_b_q}, 33'h0);
    endtask

    // Drive both units; the selected one shows sel_rdy and, when good, the true result.
    task automatic drive_units(input bit is_div, input bit sel_rdy, input bit good, input logic [32:0] m);
        mult_ready     = is_div ? 1'($urandom) : sel_rdy;
        div_ready      = is_div ? sel_rdy : 1'($urandom);
        mult_result    = (!is_div && good) ? m[31:0] : $urandom;
        mult_exception = (!is_div && good) ? m[32]   : 1'($urandom);
        div_result     = (is_div && good)  ? m[31:0] : $urandom;
        div_exception  = (is_div && good)  ? m[32]   : 1'($urandom);
    endtask

    task automatic spurious_req(input bit en);
        start_mult = en ? 1'($urandom) : 1'b0;
        start_div  = en ? 1'($urandom) : 1'b0;
        operand_a  = $urandom;
        operand_b  = $urandom;
        rd         = 5'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            spurious_req(1'b0);
            wb_ack = 1'($urandom);
            drive_units(1'($urandom), 1'($urandom), 1'b0, 33'h0);
            exp_stall = 1'b0; exp_cm = 1'b0; exp_cd = 1'b0; exp_valid = 1'b0;
        end
    endtask

    // One operation: k = WAIT cycle of first real ready (-1 = never), ad = DONE cycles before ack,
    // rst_at = WAIT cycle at which reset is slammed (-1 = none).
    task automatic run_txn(input bit is_div, input bit both, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input int k, input bit stale, input int ad,
                           input bit spur, input int rst_at);
        logic [32:0] m;
        int jend;
        m = is_div ? div_model(a, b) : mul_model(a, b);
        jend = (k < 0) ? TIMEOUT - 1 : k;

        step();
        start_mult = !is_div; start_div = is_div || both;
        operand_a = a; operand_b = b; rd = r;
        wb_ack = 1'($urandom);
        drive_units(is_div, stale, 1'b0, m);
        exp_stall = 1'b1; exp_cm = 1'b0; exp_cd = 1'b0; exp_valid = 1'b0;

        step();
        spurious_req(spur);
        wb_ack = 1'($urandom);
        drive_units(is_div, stale ? 1'b1 : 1'($urandom), 1'b0, m);
        exp_cm = !is_div; exp_cd = is_div; exp_opa = a; exp_opb = b;

        for (int j = 0; j <= jend; j++) begin
            step();
            spurious_req(spur);
            wb_ack = 1'($urandom);
            if (j < MASK) drive_units(is_div, stale ? 1'b1 : 1'($urandom), 1'b0, m);
            else          drive_units(is_div, j == k, j == k, m);
            exp_cm = 1'b0; exp_cd = 1'b0;
            if (j == rst_at) begin
                #1;
                reset = 1'b1;
                start_mult = 1'b1;
                #1;
                check_all_zero("reset_mid_wait");
                exp_stall = 1'b0; exp_opa = '0; exp_opb = '0;
                step();
                start_mult = 1'b0; start_div = 1'b0; wb_ack = 1'b0;
                step();
                reset = 1'b0;
                return;
            end
        end

        exp_data = (k < 0) ? 32'h0 : m[31:0];
        exp_exc  = (k < 0) ? 1'b1 : m[32];
        exp_rd   = r;
        for (int d = 0; d <= ad; d++) begin
            step();
            spurious_req(spur && (d != ad));
            wb_ack = (d == ad);
            drive_units(is_div, 1'($urandom), 1'b0, m);
            exp_valid = 1'b1;
            exp_stall = (d != ad);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_mult = 1'b0; start_div = 1'b0;
        operand_a = '0; operand_b = '0; rd = '0; wb_ack = 1'b0;
        mult_result = '0; div_result = '0;
        mult_exception = 1'b0; div_exception = 1'b0;
        mult_ready = 1'b0; div_ready = 1'b0;

        chk("pin_mul_7x6", mul_model(32'd7, 32'd6), {1'b0, 32'd42});
        chk("pin_mul_m3x5", mul_model(32'hFFFF_FFFD, 32'd5), {1'b0, 32'hFFFF_FFF1});
        chk("pin_div_100_7", div_model(32'd100, 32'd7), {1'b0, 32'd14});
        chk("pin_div_by0", div_model(32'd100, 32'd0), {1'b1, 32'd0});
        chk("pin_mul_ovf", mul_model(32'h0001_0000, 32'h0001_0000), {1'b1, 32'h0});

        step();
        step();
        check_all_zero("reset_state");
        reset = 1'b0;
        chk_en = 1'b1;
        idle(2);

        run_txn(1'b0, 1'b0, 32'd7, 32'd6, 5'd5, 16, 1'b0, 0, 1'b0, -1);
        idle(1);
        run_txn(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 5'd9, MASK, 1'b1, 1, 1'b0, -1);
        idle(1);
        run_txn(1'b1, 1'b0, 32'd100, 32'd7, 5'd3, 4, 1'b0, 0, 1'b0, -1);
        run_txn(1'b1, 1'b0, 32'd100, 32'd0, 5'd4, 3, 1'b1, 0, 1'b0, -1);
        idle(1);
        run_txn(1'b0, 1'b0, 32'd11, 32'd13, 5'd7, -1, 1'b1, 0, 1'b0, -1);
        run_txn(1'b0, 1'b0, 32'd2, 32'd3, 5'd8, TIMEOUT - 1, 1'b0, 0, 1'b0, -1);
        run_txn(1'b0, 1'b1, 32'd9, 32'd9, 5'd1, 5, 1'b0, 3, 1'b1, -1);
        idle(1);
        run_txn(1'b0, 1'b0, 32'd123, 32'd456, 5'd2, 30, 1'b0, 0, 1'b0, 6);
        idle(1);
        run_txn(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd6, 5, 1'b0, 0, 1'b0, -1);
        run_txn(1'b0, 1'b0, 32'd5, 32'd5, 5'd0, MASK, 1'b0, 0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            bit is_div, both;
            int k, sel;
            is_div = 1'($urandom);
            both   = ($urandom_range(0, 4) == 0);
            if (both) is_div = 1'b0;
            sel = $urandom_range(0, 7);
            if (sel == 0)      k = -1;
            else if (sel == 1) k = TIMEOUT - 1;
            else               k = $urandom_range(MASK, 20);
            run_txn(is_div, both, rnd_op(), rnd_op(), 5'($urandom), k, 1'($urandom),
                    $urandom_range(0, 3), 1'($urandom), -1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
